// File: rtl/aes256_ecb_engine.sv
`default_nettype none
// ============================================================================
// Module   : aes256_ecb_engine
// Brief    : AES-256 encrypt-only ECB core. Iterative key expander feeding a
//            fully pipelined 15-stage round datapath, AXI-Stream in and out.
// Revision : 1.0 - initial release
// ============================================================================
module aes256_ecb_engine (
    input  logic         clk,
    input  logic         rst,
    input  logic         pi_key_expand_start,
    input  logic [255:0] pi_master_key,
    output logic         po_key_ready,
    output logic         s_axis_tready,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    input  logic [127:0] s_axis_tdata,
    input  logic         m_axis_tready,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    output logic [127:0] m_axis_tdata
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_EXPAND = 2'd1;
    localparam logic [1:0] c_ST_READY  = 2'd2;
    localparam int         c_NSTAGE    = 15;

    // ---------------------------------------------------------------- GF(2^8)
    function automatic logic [7:0] f_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = f_xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine transform
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = f_gmul(sq, sq);
            inv = f_gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] f_subword(input logic [31:0] w);
        return {f_sbox(w[31:24]), f_sbox(w[23:16]), f_sbox(w[15:8]), f_sbox(w[7:0])};
    endfunction

    // SubBytes + ShiftRows; byte k sits at row k%4, column k/4
    function automatic logic [127:0] f_sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = f_sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] f_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = f_xtime(a0) ^ f_xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ f_xtime(a1) ^ f_xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ f_xtime(a2) ^ f_xtime(a3) ^ a3;
            o[103-32*c -: 8] = f_xtime(a0) ^ a0 ^ a1 ^ a2 ^ f_xtime(a3);
        end
        return o;
    endfunction

    // ------------------------------------------------------------ key schedule
    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic         w_kexp_en;
    logic [3:0]   r_kidx;
    logic [127:0] r_kprev2;
    logic [127:0] r_kprev1;
    logic [127:0] r_rk [0:c_NSTAGE-1];
    logic [31:0]  w_ktmp;
    logic [7:0]   w_rcon;
    logic [127:0] w_knew;

    // Key-expander state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state: a start pulse always (re)starts; rk14 written at index 14 ends expansion
    always_comb begin
        w_state_nxt = r_state;
        if (pi_key_expand_start) begin
            w_state_nxt = c_ST_EXPAND;
        end else begin
            case (r_state)
                c_ST_EXPAND: if (r_kidx == 4'd14) w_state_nxt = c_ST_READY;
                default:     w_state_nxt = r_state;
            endcase
        end
    end

    // Expander outputs decoded from the state
    always_comb begin
        w_kexp_en    = (r_state == c_ST_EXPAND);
        po_key_ready = (r_state == c_ST_READY);
    end

    // Next round key from the two previous ones; even indices rotate and add Rcon
    always_comb begin
        w_rcon = 8'h01 << (r_kidx[3:1] - 3'd1);
        w_ktmp = r_kidx[0] ? r_kprev1[31:0] : {r_kprev1[23:0], r_kprev1[31:24]};
        w_knew[127:96] = r_kprev2[127:96] ^ f_subword(w_ktmp)
                       ^ (r_kidx[0] ? 32'h0 : {w_rcon, 24'h0});
        w_knew[95:64]  = r_kprev2[95:64] ^ w_knew[127:96];
        w_knew[63:32]  = r_kprev2[63:32] ^ w_knew[95:64];
        w_knew[31:0]   = r_kprev2[31:0]  ^ w_knew[63:32];
    end

    // Round-key store: load rk0/rk1 on start, then one key per edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NSTAGE; i++) r_rk[i] <= '0;
            r_kprev2 <= '0;
            r_kprev1 <= '0;
            r_kidx   <= '0;
        end else if (pi_key_expand_start) begin
            r_rk[0]  <= pi_master_key[255:128];
            r_rk[1]  <= pi_master_key[127:0];
            r_kprev2 <= pi_master_key[255:128];
            r_kprev1 <= pi_master_key[127:0];
            r_kidx   <= 4'd2;
        end else if (w_kexp_en) begin
            r_rk[r_kidx] <= w_knew;
            r_kprev2     <= r_kprev1;
            r_kprev1     <= w_knew;
            r_kidx       <= r_kidx + 4'd1;
        end
    end

    // ---------------------------------------------------------------- datapath
    logic [127:0]         r_st [0:c_NSTAGE-1];
    logic [c_NSTAGE-1:0]  r_vld;
    logic [c_NSTAGE-1:0]  r_last;
    logic [127:0]         w_nxt [1:c_NSTAGE-1];
    logic                 w_adv;
    logic                 w_accept;

    // The whole pipe moves unless a valid output block is being back-pressured
    assign w_adv         = ~r_vld[c_NSTAGE-1] | m_axis_tready;
    assign s_axis_tready = po_key_ready & w_adv;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    for (genvar g = 1; g < c_NSTAGE; g++) begin : g_round
        logic [127:0] w_sr;
        assign w_sr = f_sub_shift(r_st[g-1]);
        if (g == c_NSTAGE - 1) begin : g_final
            assign w_nxt[g] = w_sr ^ r_rk[g];
        end else begin : g_mid
            assign w_nxt[g] = f_mix(w_sr) ^ r_rk[g];
        end
    end

    // Stage registers: flushed on key start, shifted when not stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NSTAGE; i++) r_st[i] <= '0;
            r_vld  <= '0;
            r_last <= '0;
        end else if (pi_key_expand_start) begin
            r_vld  <= '0;
        end else if (w_adv) begin
            r_st[0]   <= s_axis_tdata ^ r_rk[0];
            r_vld[0]  <= w_accept;
            r_last[0] <= s_axis_tlast & w_accept;
            for (int i = 1; i < c_NSTAGE; i++) begin
                r_st[i]   <= w_nxt[i];
                r_vld[i]  <= r_vld[i-1];
                r_last[i] <= r_last[i-1];
            end
        end
    end

    assign m_axis_tvalid = r_vld[c_NSTAGE-1];
    assign m_axis_tlast  = r_last[c_NSTAGE-1];
    assign m_axis_tdata  = r_st[c_NSTAGE-1];

endmodule
`default_nettype wire

// File: tb/tb_aes256_ecb_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes256_ecb_engine
// Brief    : Self-checking bench for aes256_ecb_engine: known-answer vectors,
//            random blocks against a byte-level AES-256 model, stalls, resets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes256_ecb_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         pi_key_expand_start;
    logic [255:0] pi_master_key;
    logic         po_key_ready;
    logic         s_axis_tready;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic [127:0] s_axis_tdata;
    logic         m_axis_tready;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic [127:0] m_axis_tdata;

    always #5 clk = ~clk;

    aes256_ecb_engine u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .pi_key_expand_start (pi_key_expand_start),
        .pi_master_key       (pi_master_key),
        .po_key_ready        (po_key_ready),
        .s_axis_tready       (s_axis_tready),
        .s_axis_tvalid       (s_axis_tvalid),
        .s_axis_tlast        (s_axis_tlast),
        .s_axis_tdata        (s_axis_tdata),
        .m_axis_tready       (m_axis_tready),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tdata        (m_axis_tdata)
    );

    typedef struct {
        logic [127:0] ct;
        logic         last;
        int           edge_no;
    } exp_t;

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    logic [7:0]   sbox_t [256];
    exp_t         q [$];
    logic [127:0] exp_ct;
    logic [255:0] cur_key;
    logic         lat_chk;
    logic         acc;
    logic         prev_stall;

    localparam logic [255:0] c_K1 = 256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
    localparam logic [255:0] c_K2 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;

    logic [127:0] pt_v [4];
    logic [127:0] ct_v [4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    // S-box built by brute-force inverse search plus the bitwise affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] o;
        logic [7:0] aff_c;
        aff_c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                o[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ aff_c[i];
            sbox_t[x] = o;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    // Reference AES-256 encryption on a 16-byte state array
    function automatic logic [127:0] aes_ref(input logic [255:0] key, input logic [127:0] pt);
        logic [31:0]  w [60];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8] ^ w[k/4][31-8*(k%4) -: 8];
        for (int r = 1; r <= 14; r++) begin
            for (int k = 0; k < 16; k++) t[k] = sbox_t[s[(k%4) + 4*(((k/4) + (k%4)) % 4)]];
            if (r < 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end else begin
                for (int k = 0; k < 16; k++) s[k] = t[k];
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4*r + k/4][31-8*(k%4) -: 8];
        end
        out = '0;
        for (int k = 0; k < 16; k++) out[127-8*k -: 8] = s[k];
        return out;
    endfunction

    // One clock: scoreboard checks just before the edge, then advance to edge+1
    task automatic tick();
        #1;
        if (prev_stall) chk("stall_hold_tvalid", 128'(m_axis_tvalid), 128'd1);
        if (m_axis_tvalid && !m_axis_tready) chk("stall_s_tready", 128'(s_axis_tready), 128'd0);
        if (m_axis_tvalid) begin
            if (q.size() == 0) begin
                chk("spurious_out", 128'(m_axis_tvalid), 128'd0);
            end else begin
                chk("tdata", m_axis_tdata, q[0].ct);
                chk("tlast", 128'(m_axis_tlast), 128'(q[0].last));
                if (m_axis_tready) begin
                    if (lat_chk) chk("latency", 128'(cyc - q[0].edge_no), 128'd14);
                    void'(q.pop_front());
                end
            end
        end
        acc = s_axis_tvalid && s_axis_tready;
        if (acc) q.push_back('{exp_ct, s_axis_tlast, cyc + 1});
        prev_stall = m_axis_tvalid && !m_axis_tready;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic new_blk();
        s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
        s_axis_tlast = 1'($urandom_range(1));
        exp_ct       = aes_ref(cur_key, s_axis_tdata);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) tick();
        chk("drain_empty", 128'(q.size()), 128'd0);
    endtask

    task automatic expand(input logic [255:0] k);
        pi_master_key       = k;
        pi_key_expand_start = 1'b1;
        tick();
        pi_key_expand_start = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("key_ready_early", 128'(po_key_ready), 128'd0);
        end
        tick();
        chk("key_ready_e13", 128'(po_key_ready), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pt_v[0] = 128'h6BC1BEE22E409F96E93D7E117393172A; ct_v[0] = 128'hF3EED1BDB5D2A03C064B5A7E3DB181F8;
        pt_v[1] = 128'hAE2D8A571E03AC9C9EB76FAC45AF8E51; ct_v[1] = 128'h591CCB10D410ED26DC5BA74A31362870;
        pt_v[2] = 128'h30C81C46A35CE411E5FBC1191A0A52EF; ct_v[2] = 128'hB6ED21B99CA6F4F9F153E7B1BEAFED1D;
        pt_v[3] = 128'hF69F2445DF4F9B17AD2B417BE66C3710; ct_v[3] = 128'h23304B7A39F9F3FF067D8D8F9E24ECC7;
        rst = 1'b1; pi_key_expand_start = 1'b0; pi_master_key = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tdata = '0;
        m_axis_tready = 1'b1; exp_ct = '0; cur_key = c_K1; lat_chk = 1'b0;
        acc = 1'b0; prev_stall = 1'b0;
        build_sbox();

        // Reset held five cycles
        #2 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_key_ready", 128'(po_key_ready), 128'd0);
        chk("rst_tvalid", 128'(m_axis_tvalid), 128'd0);
        chk("rst_tlast", 128'(m_axis_tlast), 128'd0);
        chk("rst_tdata", m_axis_tdata, 128'd0);
        chk("rst_s_tready", 128'(s_axis_tready), 128'd0);
        rst = 1'b1;
        tick();

        // Key 1 expansion, then idle with no input
        expand(c_K1);
        repeat (20) tick();
        chk("idle_tvalid", 128'(m_axis_tvalid), 128'd0);

        // Four back-to-back known-answer blocks
        lat_chk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pt_v[i];
            s_axis_tlast  = (i == 3);
            exp_ct        = ct_v[i];
            chk("s_tready_open", 128'(s_axis_tready), 128'd1);
            tick();
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        drain();

        // Isolated block
        repeat (5) tick();
        s_axis_tvalid = 1'b1; s_axis_tdata = pt_v[1]; s_axis_tlast = 1'b0; exp_ct = ct_v[1];
        tick();
        s_axis_tvalid = 1'b0;
        drain();

        // Continuous random stream with a three-cycle output stall
        lat_chk = 1'b0;
        s_axis_tvalid = 1'b1;
        new_blk();
        for (int j = 0; j < 30; j++) begin
            m_axis_tready = !(j >= 16 && j < 19);
            tick();
            if (acc) begin
                if (j < 20) new_blk();
                else        s_axis_tvalid = 1'b0;
            end
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        drain();

        // Random valid / ready patterns
        for (int b = 0; b < 40; b++) begin
            new_blk();
            s_axis_tvalid = 1'b1;
            for (int g = 0; g < 50; g++) begin
                m_axis_tready = ($urandom_range(3) != 0);
                tick();
                if (acc) break;
            end
            chk("accept_bound", 128'(acc), 128'd1);
            s_axis_tvalid = 1'b0;
            if ($urandom_range(2) == 0) tick();
        end
        m_axis_tready = 1'b1;
        drain();

        // Restart during expansion: K1 aborted after a few edges, K2 wins
        pi_master_key = c_K1; pi_key_expand_start = 1'b1;
        tick();
        pi_key_expand_start = 1'b0;
        repeat (4) tick();
        chk("restart_key_ready", 128'(po_key_ready), 128'd0);
        cur_key = c_K2;
        expand(c_K2);
        lat_chk = 1'b1;
        s_axis_tvalid = 1'b1; s_axis_tdata = 128'h00112233445566778899AABBCCDDEEFF;
        s_axis_tlast = 1'b1; exp_ct = 128'h8EA2B7CA516745BFEAFC49904B496089;
        tick();
        s_axis_tvalid = 1'b0;
        drain();
        s_axis_tvalid = 1'b1;
        for (int j = 0; j < 10; j++) begin
            new_blk();
            tick();
        end
        s_axis_tvalid = 1'b0;
        drain();

        // Asynchronous reset in the middle of a stream
        lat_chk = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int j = 0; j < 18; j++) begin
            new_blk();
            tick();
        end
        rst = 1'b0;
        #1;
        chk("midrst_tvalid", 128'(m_axis_tvalid), 128'd0);
        chk("midrst_tdata", m_axis_tdata, 128'd0);
        chk("midrst_tlast", 128'(m_axis_tlast), 128'd0);
        chk("midrst_key_ready", 128'(po_key_ready), 128'd0);
        chk("midrst_s_tready", 128'(s_axis_tready), 128'd0);
        q.delete();
        prev_stall    = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Recovery after reset
        lat_chk = 1'b1;
        expand(c_K2);
        s_axis_tvalid = 1'b1; s_axis_tdata = 128'h00112233445566778899AABBCCDDEEFF;
        s_axis_tlast = 1'b0; exp_ct = 128'h8EA2B7CA516745BFEAFC49904B496089;
        tick();
        s_axis_tvalid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes256_ecb_engine.md
Name: aes256_ecb_engine

Overview:
- AES-256 block encryptor (FIPS-197, encrypt direction only) between a 128-bit AXI-Stream slave input and a 128-bit AXI-Stream master output.
- An iterative key expander loads a 256-bit master key and builds all 15 round keys.
- A fully pipelined 14-round datapath then encrypts one block per clock, independently per block (ECB).
- It serves as the block-cipher core for the higher-level CTR wrapper.

Parameters:
- none (AES-256 fixed: Nk=8, Nr=14)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- pi_key_expand_start  in  1  one-cycle pulse; samples pi_master_key and starts key expansion
- pi_master_key  in  256  cipher key; bits [255:248] are key byte 0
- po_key_ready  out  1  high when all round keys are valid
- s_axis_tready  out  1  input ready
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  input last flag, carried with the block
- s_axis_tdata  in  128  plaintext; bits [127:120] are state byte 0 (column-major order)
- m_axis_tready  in  1  downstream ready
- m_axis_tvalid  out  1  ciphertext valid
- m_axis_tlast  out  1  tlast of the corresponding input block
- m_axis_tdata  out  128  ciphertext, same byte order as the input

Behaviour:
- Reset (rst=0, async): po_key_ready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0. All pipeline valid bits and the round-key store are cleared. s_axis_tready=0.
- Key expansion, edge E0 (pi_key_expand_start=1 sampled):
  - rk0 = key[255:128], rk1 = key[127:0].
  - po_key_ready drops to 0.
  - All pipeline valid bits clear (flush).
- Key expansion, edges E1..E13: one round key per edge (rk2..rk14), following the standard FIPS-197 schedule.
  - Even rk: first word uses RotWord, SubWord and Rcon; Rcon sequence 01,02,04,08,10,20,40.
  - Odd rk: first word uses SubWord only.
  - Remaining words are XOR chains.
- po_key_ready rises after edge E13 and stays high until the next start or reset.
- A start pulse during expansion restarts expansion from E0 with the newly sampled key.
- s_axis_tready = po_key_ready AND (NOT m_axis_tvalid OR m_axis_tready).
- A block is accepted when s_axis_tvalid AND s_axis_tready. When tready=0, input is ignored and the source must hold it.
- Pipeline has 15 register stages:
  - Stage 0: state XOR rk0.
  - Stages 1..13: SubBytes, ShiftRows, MixColumns, XOR rk_i.
  - Stage 14: SubBytes, ShiftRows, XOR rk14 (no MixColumns).
- Latency: the block accepted at edge N appears on m_axis_* after edge N+14 when the pipeline is not stalled.
- Throughput: one block per cycle back-to-back.
- tlast travels with its block through every stage.
- Stall rule: when m_axis_tvalid=1 and m_axis_tready=0, the whole pipeline holds. Output data, tvalid and tlast stay stable until the handshake completes.
- Bubbles (invalid stages) advance normally and carry no valid flag.
- S-box: standard AES forward S-box, implementable as a table or GF(2^8) inverse plus affine transform. It is shared logic form only; each stage has its own 16 instances, and the key expander has 4.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11B.

Test Plan:
- Reset held 5 cycles, then released -> all outputs 0, s_axis_tready=0; after expansion with no input, m_axis_tvalid stays 0.
- Start with key 603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4 -> po_key_ready=1 exactly after the 13th following edge.
- With that key, send 4 back-to-back blocks (the 4th with tlast=1), m_axis_tready=1, each output arriving 14 cycles after its input on consecutive cycles:
  - 6BC1BEE22E409F96E93D7E117393172A -> F3EED1BDB5D2A03C064B5A7E3DB181F8
  - AE2D8A571E03AC9C9EB76FAC45AF8E51 -> 591CCB10D410ED26DC5BA74A31362870
  - 30C81C46A35CE411E5FBC1191A0A52EF -> B6ED21B99CA6F4F9F153E7B1BEAFED1D
  - F69F2445DF4F9B17AD2B417BE66C3710 -> 23304B7A39F9F3FF067D8D8F9E24ECC7, with m_axis_tlast=1 on this block only
- Isolated block AE2D8A57...8E51 sent later -> again 591CCB10...2870, tlast=0.
- Key 000102...1E1F, block 00112233445566778899AABBCCDDEEFF -> 8EA2B7CA516745BFEAFC49904B496089.
- Drop m_axis_tready for 3 cycles mid-stream -> output held stable, s_axis_tready=0 during the stall, no block lost or duplicated; assert rst mid-stream -> outputs cleared immediately.
